// File: rtl/sensor_debounce_if.sv
// Signal bundle between the raw cabin sensor pins and the debounced outputs of sensor_debounce.
interface sensor_debounce_if #(
    parameter int N_CH = 5
);
    logic            sample_en;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] clean_out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            busy;

    modport master (
        output sample_en,
        output raw_in,
        input  clean_out,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  sample_en,
        input  raw_in,
        output clean_out,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/sensor_debounce.sv
// Per-channel sensor debouncer: optional two-flop synchronizer, stability counter, rise/fall pulses.
// Macro SENSOR_DEBOUNCE_SYNC_EN enables the input synchronizer (production setting).
module sensor_debounce #(
    parameter int            N_CH          = 5,
    parameter int            STABLE_CYCLES = 16,
    parameter logic [N_CH-1:0] RESET_VAL   = {N_CH{1'b0}},
    localparam int           CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic              clk,
    input  logic              reset,
    sensor_debounce_if.slave  bus
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [N_CH-1:0]  samp_s;
    logic [N_CH-1:0]  mismatch_s;
    logic [N_CH-1:0]  flip_s;
    state_t           state_r    [N_CH];
    state_t           state_nx_s [N_CH];
    logic [CNT_W-1:0] cnt_r      [N_CH];
    logic [CNT_W-1:0] cnt_nx_s   [N_CH];
    logic [N_CH-1:0]  clean_r;
    logic [N_CH-1:0]  rise_r;
    logic [N_CH-1:0]  fall_r;
    logic [N_CH-1:0]  clean_nx_s;
    logic [N_CH-1:0]  rise_nx_s;
    logic [N_CH-1:0]  fall_nx_s;
    logic             busy_s;

`ifdef SENSOR_DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] sync1_r;
    logic [N_CH-1:0] sync2_r;

    // Two-flop synchronizer for the asynchronous sensor pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
        end else begin
            sync1_r <= bus.raw_in;
            sync2_r <= sync1_r;
        end
    end

    assign samp_s = sync2_r;
`else
    assign samp_s = bus.raw_in;
`endif

    assign mismatch_s = samp_s ^ clean_r;

    // State register plus registered counters, clean levels and event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= ST_STABLE;
                cnt_r[i]   <= CNT_ZERO;
            end
            clean_r <= RESET_VAL;
            rise_r  <= {N_CH{1'b0}};
            fall_r  <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= state_nx_s[i];
                cnt_r[i]   <= cnt_nx_s[i];
            end
            clean_r <= clean_nx_s;
            rise_r  <= rise_nx_s;
            fall_r  <= fall_nx_s;
        end
    end

    // Next-state logic; a match on any cycle, enabled or not, abandons the pending flip
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nx_s[i] = state_r[i];
            flip_s[i]     = 1'b0;
            case (state_r[i])
                ST_STABLE: begin
                    if (bus.sample_en && mismatch_s[i]) begin
                        state_nx_s[i] = ST_PENDING;
                    end else begin
                        state_nx_s[i] = ST_STABLE;
                    end
                end
                ST_PENDING: begin
                    if (!mismatch_s[i]) begin
                        state_nx_s[i] = ST_STABLE;
                    end else if (bus.sample_en && (cnt_r[i] == CNT_MAX)) begin
                        state_nx_s[i] = ST_STABLE;
                        flip_s[i]     = 1'b1;
                    end else begin
                        state_nx_s[i] = ST_PENDING;
                    end
                end
                default: begin
                    state_nx_s[i] = ST_STABLE;
                end
            endcase
        end
    end

    // Counter datapath, next clean level, event pulses and busy flag
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nx_s[i] = cnt_r[i];
            case (state_r[i])
                ST_STABLE: begin
                    if (bus.sample_en && mismatch_s[i]) begin
                        cnt_nx_s[i] = CNT_ONE;
                    end else begin
                        cnt_nx_s[i] = CNT_ZERO;
                    end
                end
                ST_PENDING: begin
                    busy_s = 1'b1;
                    if (!mismatch_s[i] || flip_s[i]) begin
                        cnt_nx_s[i] = CNT_ZERO;
                    end else if (bus.sample_en) begin
                        cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
                    end else begin
                        cnt_nx_s[i] = cnt_r[i];
                    end
                end
                default: begin
                    cnt_nx_s[i] = CNT_ZERO;
                end
            endcase
        end
        clean_nx_s = (clean_r & ~flip_s) | (samp_s & flip_s);
        rise_nx_s  = flip_s & samp_s;
        fall_nx_s  = flip_s & ~samp_s;
    end

    assign bus.clean_out = clean_r;
    assign bus.rise      = rise_r;
    assign bus.fall      = fall_r;
    assign bus.busy      = busy_s;

endmodule

// File: tb/tb_sensor_debounce.sv
// Scoreboard bench for sensor_debounce: stimulus queues expected flip events, a negedge monitor checks them.
module tb_sensor_debounce;
    localparam int N = 5;
    localparam int S = 4;
`ifdef SENSOR_DEBOUNCE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    typedef struct {
        int         edge_n;
        logic [4:0] rise;
        logic [4:0] fall;
        logic [4:0] clean;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    sensor_debounce_if #(.N_CH(N)) bus_if ();

    sensor_debounce #(
        .N_CH(N),
        .STABLE_CYCLES(S),
        .RESET_VAL(5'b00000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int e, input logic [4:0] r, input logic [4:0] f, input logic [4:0] c);
        exp_t x;
        x.edge_n = e;
        x.rise   = r;
        x.fall   = f;
        x.clean  = c;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus_if.raw_in    = 5'b00000;
        bus_if.sample_en = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Monitor: every rise/fall activity must match the next queued event
    always @(negedge clk) begin
        exp_t e;
        if ((bus_if.rise | bus_if.fall) !== 5'b00000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: rise=%b fall=%b at edge %0d, expected none",
                         bus_if.rise, bus_if.fall, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                check("event_edge", edge_cnt, e.edge_n);
                check("event_rise", bus_if.rise, e.rise);
                check("event_fall", bus_if.fall, e.fall);
                check("event_clean", bus_if.clean_out, e.clean);
            end
        end
    end

    initial begin
        int       base;
        int       flip_k;
        int       en_cnt;
        logic     busy_seen;
        exp_t     left;

        // Reset with active pins: nothing leaks through until released
        reset            = 1'b1;
        bus_if.raw_in    = 5'b10101;
        bus_if.sample_en = 1'b1;
        step(1);
        check("rst_clean", bus_if.clean_out, 5'b00000);
        check("rst_rise", bus_if.rise, 5'b00000);
        check("rst_fall", bus_if.fall, 5'b00000);
        check("rst_busy", bus_if.busy, 1'b0);
        step(1);
        check("rst_clean2", bus_if.clean_out, 5'b00000);
        reset = 1'b0;
        base  = edge_cnt;
        push(base + S + L, 5'b10101, 5'b00000, 5'b10101);
        step(S + L + 3);
        check("rst_release_clean", bus_if.clean_out, 5'b10101);
        check("rst_release_busy", bus_if.busy, 1'b0);

        // Clean single edge
        do_reset();
        base          = edge_cnt;
        bus_if.raw_in = 5'b00100;
        push(base + S + L, 5'b00100, 5'b00000, 5'b00100);
        step(S + L + 3);
        check("edge_clean", bus_if.clean_out, 5'b00100);

        // Bounce on channel 1 must be rejected
        do_reset();
        busy_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus_if.raw_in = (k % 2 == 0) ? 5'b00010 : 5'b00000;
            step(1);
            busy_seen = busy_seen | bus_if.busy;
        end
        bus_if.raw_in = 5'b00000;
        step(S + L + 3);
        check("bounce_busy_seen", busy_seen, 1'b1);
        check("bounce_clean", bus_if.clean_out, 5'b00000);
        check("bounce_busy_idle", bus_if.busy, 1'b0);

        // Gated sampling: enable on every third edge only
        do_reset();
        base   = edge_cnt;
        en_cnt = 0;
        flip_k = 0;
        for (int k = L; k < 40; k++) begin
            if (k % 3 == 2) en_cnt++;
            if (en_cnt == S) begin
                flip_k = k;
                break;
            end
        end
        bus_if.raw_in = 5'b10000;
        push(base + 1 + flip_k, 5'b10000, 5'b00000, 5'b10000);
        for (int k = 0; k < 20; k++) begin
            bus_if.sample_en = (k % 3 == 2);
            step(1);
            if (k == flip_k - 1) check("gated_not_before", bus_if.clean_out, 5'b00000);
        end
        bus_if.sample_en = 1'b1;
        step(3);
        check("gated_clean", bus_if.clean_out, 5'b10000);

        // Simultaneous rise and fall on different channels
        do_reset();
        base          = edge_cnt;
        bus_if.raw_in = 5'b11000;
        push(base + S + L, 5'b11000, 5'b00000, 5'b11000);
        step(S + L + 3);
        base          = edge_cnt;
        bus_if.raw_in = 5'b00011;
        push(base + S + L, 5'b00011, 5'b11000, 5'b00011);
        step(S + L + 3);
        check("simul_clean", bus_if.clean_out, 5'b00011);

        // Reset on E3 discards the partial count, count restarts afterwards
        do_reset();
        base          = edge_cnt;
        bus_if.raw_in = 5'b00001;
        push(base + 1 + 3 + S + L, 5'b00001, 5'b00000, 5'b00001);
        step(3);
        reset = 1'b1;
        step(1);
        check("midrst_clean", bus_if.clean_out, 5'b00000);
        check("midrst_rise", bus_if.rise, 5'b00000);
        check("midrst_busy", bus_if.busy, 1'b0);
        reset = 1'b0;
        step(1);
        check("midrst_rise_next", bus_if.rise, 5'b00000);
        step(S + L + 4);
        check("midrst_clean_final", bus_if.clean_out, 5'b00001);

        // Drain: any event still queued was never produced
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) step(1);
        while (exp_q.size() > 0) begin
            left = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event: no activity, expected rise=%b fall=%b at edge %0d",
                     left.rise, left.fall, left.edge_n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
